// File: rtl/dot_vector_loader.sv
// Byte-stream front-end for the parallel dot-product engine: fills A/B buffers, starts the engine, returns its result.
// Optional per-job byte checksum is built only when DOT_LOADER_CHECKSUM_EN is defined.
module dot_vector_loader #(
   parameter int unsigned VECTOR_SIZE = 1024,
   parameter int unsigned IDX_W       = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_data,
   output logic [8*VECTOR_SIZE-1:0] vec_A_flat,
   output logic [8*VECTOR_SIZE-1:0] vec_B_flat,
   output logic                     dp_start,
   input  logic                     dp_done,
   input  logic [31:0]              dp_result,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [31:0]              res_data,
   output logic                     busy,
   output logic [15:0]              job_count,
   output logic [15:0]              checksum
);
   localparam int unsigned BUF_W = 8 * VECTOR_SIZE;
   localparam int unsigned BIT_W = IDX_W + 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL_A,
      S_FILL_B,
      S_START,
      S_WAIT_DP,
      S_RESULT
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [IDX_W-1:0]   r_elem_cnt;
   logic [BUF_W-1:0]   r_vec_a;
   logic [BUF_W-1:0]   r_vec_b;
   logic               r_dp_start;
   logic               r_res_valid;
   logic [31:0]        r_res_data;
   logic [15:0]        r_job_count;
   logic               w_xfer;
   logic               w_last;
   logic               w_res_hs;
   logic [BIT_W-1:0]   w_bit_idx;

   assign in_ready  = (r_state == S_FILL_A) || (r_state == S_FILL_B);
   assign w_xfer    = in_valid && in_ready;
   assign w_last    = (r_elem_cnt == IDX_W'(VECTOR_SIZE - 1));
   assign w_res_hs  = r_res_valid && res_ready;
   assign w_bit_idx = {r_elem_cnt, 3'b000};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = S_FILL_A;
         S_FILL_A:  if (w_xfer && w_last) w_next = S_FILL_B;
         S_FILL_B:  if (w_xfer && w_last) w_next = S_START;
         S_START:   w_next = S_WAIT_DP;
         S_WAIT_DP: if (dp_done) w_next = S_RESULT;
         S_RESULT:  if (w_res_hs) w_next = S_FILL_A;
         default:   w_next = S_IDLE;
      endcase
   end

   // Element counter and operand buffers; only written while filling
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_elem_cnt <= '0;
         r_vec_a    <= '0;
         r_vec_b    <= '0;
      end else if (w_xfer) begin
         r_elem_cnt <= w_last ? '0 : r_elem_cnt + IDX_W'(1);
         if (r_state == S_FILL_A) r_vec_a[w_bit_idx +: 8] <= in_data;
         else                     r_vec_b[w_bit_idx +: 8] <= in_data;
      end
   end

   // Engine start pulse, result capture and job accounting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dp_start  <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_job_count <= '0;
      end else begin
         r_dp_start <= (w_next == S_START);
         if ((r_state == S_WAIT_DP) && dp_done) begin
            r_res_data  <= dp_result;
            r_res_valid <= 1'b1;
         end else if (w_res_hs) begin
            r_res_valid <= 1'b0;
            r_job_count <= r_job_count + 16'(1);
         end
      end
   end

`ifdef DOT_LOADER_CHECKSUM_EN
   logic [15:0] r_checksum;

   // Running modular byte sum of the current job
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_checksum <= '0;
      else if (w_res_hs) r_checksum <= '0;
      else if (w_xfer)   r_checksum <= r_checksum + 16'(in_data);
   end

   assign checksum = r_checksum;
`else
   assign checksum = 16'h0000;
`endif

   assign vec_A_flat = r_vec_a;
   assign vec_B_flat = r_vec_b;
   assign dp_start   = r_dp_start;
   assign res_valid  = r_res_valid;
   assign res_data   = r_res_data;
   assign job_count  = r_job_count;
   assign busy       = !((r_state == S_FILL_A) && (r_elem_cnt == '0));

endmodule
